// File: rtl/tdc_coarse_cnt_if.sv
// Valid/ready stream carrying captured coarse hits, {stop_s, count} per word.
interface tdc_coarse_cnt_if #(
  parameter int CNT_W = 8
);
  logic             valid;
  logic             ready;
  logic [CNT_W:0]   data;
  logic             last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/tdc_coarse_cnt.sv
// TDC coarse stage: counts clk5 cycles in the measurement window, snapshots
// the count on each stop pulse and streams the captured hits out afterwards.
//
// state | meaning
// IDLE  | waiting for cnt_en; count held at 0
// RUN   | counting, capturing stops into the hit buffer
// DRAIN | streaming captured hits; count frozen, stops ignored
module tdc_coarse_cnt #(
  parameter int CNT_W    = 8,
  parameter int MAX_HITS = 4,
  parameter int HIT_W    = 3
) (
  input  logic              clk5,
  input  logic              rst_n,
  input  logic              cnt_en,
  input  logic              coarse_tri,
  input  logic              stop_s,
  input  logic              tdc_clr,
  output logic              overflow,
  output logic              hit_drop,
  output logic              busy,
  output logic [HIT_W-1:0]  hit_num,
  tdc_coarse_cnt_if.master  dout
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [CNT_W-1:0] MAX_COUNT = '1;
  localparam logic [HIT_W-1:0] HITS_MAX  = HIT_W'(MAX_HITS);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [HIT_W-1:0] rd_idx;
  logic             valid_q;
  logic [CNT_W:0]   hit_buf [2**HIT_W];

  logic full, cap, at_max, done, last_w;

  always_comb begin
    full   = (hit_num == HITS_MAX);
    cap    = coarse_tri && !full;
    at_max = cnt_en && (count == MAX_COUNT);
    done   = !cnt_en || at_max || (cap && (hit_num == HITS_MAX - HIT_W'(1)));
    last_w = (rd_idx == hit_num - HIT_W'(1));
  end

  // Buffer contents need no reset: they are only visible while valid_q is high.
  always_ff @(posedge clk5) begin
    if (state == RUN && cap && !tdc_clr)
      hit_buf[hit_num] <= {stop_s, count};
  end

  always_ff @(posedge clk5 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      hit_num  <= '0;
      rd_idx   <= '0;
      valid_q  <= 1'b0;
      overflow <= 1'b0;
      hit_drop <= 1'b0;
    end else if (tdc_clr) begin
      state    <= IDLE;
      count    <= '0;
      hit_num  <= '0;
      rd_idx   <= '0;
      valid_q  <= 1'b0;
      overflow <= 1'b0;
      hit_drop <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cnt_en) begin
            state   <= RUN;
            count   <= CNT_W'(1);
            hit_num <= '0;
            rd_idx  <= '0;
          end
        end
        RUN: begin
          if (cap)
            hit_num <= hit_num + HIT_W'(1);
          else if (coarse_tri)
            hit_drop <= 1'b1;
          if (cnt_en && count != MAX_COUNT)
            count <= count + CNT_W'(1);
          if (at_max)
            overflow <= 1'b1;
          if (done) begin
            state   <= DRAIN;
            rd_idx  <= '0;
            valid_q <= cap || (hit_num != '0);
          end
        end
        DRAIN: begin
          if (hit_num == '0) begin
            state <= IDLE;
            count <= '0;
          end else if (valid_q && dout.ready) begin
            if (last_w) begin
              valid_q <= 1'b0;
              state   <= IDLE;
              count   <= '0;
            end else begin
              rd_idx <= rd_idx + HIT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign dout.valid = valid_q;
  assign dout.data  = valid_q ? hit_buf[rd_idx] : '0;
  assign dout.last  = valid_q && last_w;

endmodule

// File: tb/tb_tdc_coarse_cnt.sv
// Directed bench for tdc_coarse_cnt: a 4-hit and an 8-hit instance share the stimulus.
module tb_tdc_coarse_cnt;

  logic       clk5 = 1'b0;
  logic       rst_n, cnt_en, coarse_tri, stop_s, tdc_clr;
  logic       overflow, hit_drop, busy;
  logic [2:0] hit_num;
  logic       overflow8, hit_drop8, busy8;
  logic [3:0] hit_num8;

  int n_chk  = 0;
  int n_fail = 0;

  logic [8:0] wq[$];
  logic       lq[$];
  logic [8:0] wq8[$];
  logic       lq8[$];

  tdc_coarse_cnt_if #(.CNT_W(8)) dout ();
  tdc_coarse_cnt_if #(.CNT_W(8)) dout8 ();

  tdc_coarse_cnt #(.CNT_W(8), .MAX_HITS(4), .HIT_W(3)) dut (
    .clk5(clk5), .rst_n(rst_n), .cnt_en(cnt_en), .coarse_tri(coarse_tri),
    .stop_s(stop_s), .tdc_clr(tdc_clr), .overflow(overflow), .hit_drop(hit_drop),
    .busy(busy), .hit_num(hit_num), .dout(dout)
  );

  tdc_coarse_cnt #(.CNT_W(8), .MAX_HITS(8), .HIT_W(4)) dut8 (
    .clk5(clk5), .rst_n(rst_n), .cnt_en(cnt_en), .coarse_tri(coarse_tri),
    .stop_s(stop_s), .tdc_clr(tdc_clr), .overflow(overflow8), .hit_drop(hit_drop8),
    .busy(busy8), .hit_num(hit_num8), .dout(dout8)
  );

  always #5 clk5 = ~clk5;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk5);
    #1;
  endtask

  task automatic clear_inputs;
    cnt_en     = 1'b0;
    coarse_tri = 1'b0;
    stop_s     = 1'b0;
    tdc_clr    = 1'b0;
    dout.ready  = 1'b1;
    dout8.ready = 1'b1;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
    wq.delete(); lq.delete(); wq8.delete(); lq8.delete();
  endtask

  // Set inputs for the next edge, log any handshake that edge completes, then advance.
  task automatic step(input logic ce, input logic tr, input logic ss);
    cnt_en = ce; coarse_tri = tr; stop_s = ss;
    if (dout.valid && dout.ready) begin
      wq.push_back(dout.data); lq.push_back(dout.last);
    end
    if (dout8.valid && dout8.ready) begin
      wq8.push_back(dout8.data); lq8.push_back(dout8.last);
    end
    tick();
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 1'b0;
    #3;
    n_chk++;
    if ({overflow, hit_drop, busy, hit_num, dout.valid, dout.data, dout.last} !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h required 0",
               {overflow, hit_drop, busy, hit_num, dout.valid, dout.data, dout.last});
    end
    do_reset();
  endtask

  task automatic test_single_hit;
    logic [8:0] w0;
    do_reset();
    step(1'b0, 1'b1, 1'b1);
    n_chk++;
    if ({busy, hit_num} !== 4'h0) begin
      n_fail++; $display("FAIL idle_stop_ignored got %h required 0", {busy, hit_num});
    end
    step(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 25; e++) begin
      step(e < 20, e == 10, e == 10);
      if (e == 20) begin
        n_chk++;
        if ({busy, dout.valid, dout.data, dout.last} !== {1'b1, 1'b1, 9'h10A, 1'b1}) begin
          n_fail++;
          $display("FAIL single_drain_word got %h required %h",
                   {busy, dout.valid, dout.data, dout.last}, {1'b1, 1'b1, 9'h10A, 1'b1});
        end
      end
    end
    n_chk++;
    if (wq.size() !== 1) begin
      n_fail++; $display("FAIL single_count got %0d required 1", wq.size());
    end
    w0 = (wq.size() > 0) ? wq[0] : 9'hxxx;
    n_chk++;
    if (w0 !== 9'h10A) begin
      n_fail++; $display("FAIL single_word got %h required 10a", w0);
    end
    n_chk++;
    if ({hit_num, busy, dout.valid} !== {3'd1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL single_end got %h required %h", {hit_num, busy, dout.valid}, {3'd1, 2'b00});
    end
  endtask

  task automatic test_four_hits;
    logic [35:0] got;
    logic [3:0]  lst;
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 20; e++) begin
      step(e < 10, e inside {3, 5, 7, 9, 11}, 1'b0);
      if (e == 9) begin
        n_chk++;
        if ({busy, dout.valid, dout.data, dout.last} !== {1'b1, 1'b1, 9'h003, 1'b0}) begin
          n_fail++;
          $display("FAIL full_drain_entry got %h required %h",
                   {busy, dout.valid, dout.data, dout.last}, {1'b1, 1'b1, 9'h003, 1'b0});
        end
      end
    end
    n_chk++;
    if (wq.size() !== 4) begin
      n_fail++; $display("FAIL full_count got %0d required 4", wq.size());
    end
    got = (wq.size() == 4) ? {wq[0], wq[1], wq[2], wq[3]} : 'x;
    lst = (lq.size() == 4) ? {lq[0], lq[1], lq[2], lq[3]} : 'x;
    n_chk++;
    if (got !== {9'h003, 9'h005, 9'h007, 9'h009}) begin
      n_fail++; $display("FAIL full_words got %h required 003005007009", got);
    end
    n_chk++;
    if (lst !== 4'b0001) begin
      n_fail++; $display("FAIL full_last got %b required 0001", lst);
    end
    n_chk++;
    if ({hit_drop, hit_num, busy} !== {1'b0, 3'd4, 1'b0}) begin
      n_fail++; $display("FAIL full_status got %h required %h", {hit_drop, hit_num, busy}, {1'b0, 3'd4, 1'b0});
    end
  endtask

  task automatic test_deep_buffer;
    logic [44:0] got;
    logic [4:0]  lst;
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 30; e++)
      step(e < 20, e inside {3, 5, 7, 9, 11}, 1'b0);
    n_chk++;
    if (wq8.size() !== 5) begin
      n_fail++; $display("FAIL deep_count got %0d required 5", wq8.size());
    end
    got = (wq8.size() == 5) ? {wq8[0], wq8[1], wq8[2], wq8[3], wq8[4]} : 'x;
    lst = (lq8.size() == 5) ? {lq8[0], lq8[1], lq8[2], lq8[3], lq8[4]} : 'x;
    n_chk++;
    if (got !== {9'h003, 9'h005, 9'h007, 9'h009, 9'h00B}) begin
      n_fail++; $display("FAIL deep_words got %h required 00300500700900b", got);
    end
    n_chk++;
    if (lst !== 5'b00001) begin
      n_fail++; $display("FAIL deep_last got %b required 00001", lst);
    end
    n_chk++;
    if ({hit_num8, busy8, hit_drop8} !== {4'd5, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL deep_status got %h required %h", {hit_num8, busy8, hit_drop8}, {4'd5, 2'b00});
    end
  endtask

  task automatic test_overflow;
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 256; e++) begin
      step(e <= 255, 1'b0, 1'b0);
      if (e == 254) begin
        n_chk++;
        if ({overflow, busy} !== 2'b01) begin
          n_fail++; $display("FAIL ovf_before got %b required 01", {overflow, busy});
        end
      end
      if (e == 255) begin
        n_chk++;
        if ({overflow, dout.valid} !== 2'b10) begin
          n_fail++; $display("FAIL ovf_set got %b required 10", {overflow, dout.valid});
        end
      end
      if (e == 256) begin
        n_chk++;
        if ({busy, hit_num} !== 4'h0) begin
          n_fail++; $display("FAIL ovf_idle got %h required 0", {busy, hit_num});
        end
      end
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    n_chk++;
    if ({overflow, wq.size() == 0} !== 2'b11) begin
      n_fail++; $display("FAIL ovf_sticky got %b required 11", {overflow, wq.size() == 0});
    end
    tdc_clr = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    tdc_clr = 1'b0;
    n_chk++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear got %b required 0", overflow);
    end
  endtask

  task automatic test_backpressure;
    logic [17:0] got;
    logic [1:0]  lst;
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 20; e++) begin
      dout.ready = !(e >= 7 && e <= 11);
      step(e < 6, e == 2 || e == 4, e == 4);
      if (e >= 6 && e <= 11) begin
        n_chk++;
        if ({dout.valid, dout.data, dout.last} !== {1'b1, 9'h002, 1'b0}) begin
          n_fail++;
          $display("FAIL stall_hold_e%0d got %h required %h", e,
                   {dout.valid, dout.data, dout.last}, {1'b1, 9'h002, 1'b0});
        end
      end
    end
    dout.ready = 1'b1;
    got = (wq.size() == 2) ? {wq[0], wq[1]} : 'x;
    lst = (lq.size() == 2) ? {lq[0], lq[1]} : 'x;
    n_chk++;
    if (got !== {9'h002, 9'h104}) begin
      n_fail++; $display("FAIL stall_words got %h required 002104", got);
    end
    n_chk++;
    if (lst !== 2'b01) begin
      n_fail++; $display("FAIL stall_last got %b required 01", lst);
    end
  endtask

  task automatic test_clear_and_reset;
    logic [8:0] w0;
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 6; e++) begin
      tdc_clr = (e == 6);
      step(1'b1, e == 2, e == 2);
    end
    tdc_clr = 1'b0;
    n_chk++;
    if ({overflow, hit_drop, busy, hit_num, dout.valid, dout.data, dout.last} !== 17'h0) begin
      n_fail++;
      $display("FAIL clr_outputs got %h required 0",
               {overflow, hit_drop, busy, hit_num, dout.valid, dout.data, dout.last});
    end
    dout.ready = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 8; e++) step(e < 8, e == 4, 1'b0);
    n_chk++;
    if ({busy, hit_num, dout.valid, dout.data} !== {1'b1, 3'd1, 1'b1, 9'h004}) begin
      n_fail++;
      $display("FAIL pre_rst_drain got %h required %h",
               {busy, hit_num, dout.valid, dout.data}, {1'b1, 3'd1, 1'b1, 9'h004});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({overflow, hit_drop, busy, hit_num, dout.valid, dout.data, dout.last} !== 17'h0) begin
      n_fail++;
      $display("FAIL async_rst got %h required 0",
               {overflow, hit_drop, busy, hit_num, dout.valid, dout.data, dout.last});
    end
    #4;
    rst_n = 1'b1;
    tick();
    wq.delete(); lq.delete();
    dout.ready = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 12; e++) step(e < 6, e == 3, e == 3);
    w0 = (wq.size() == 1) ? wq[0] : 9'hxxx;
    n_chk++;
    if (w0 !== 9'h103) begin
      n_fail++; $display("FAIL post_rst_word got %h required 103", w0);
    end
    n_chk++;
    if ({hit_num, busy} !== {3'd1, 1'b0}) begin
      n_fail++; $display("FAIL post_rst_status got %h required %h", {hit_num, busy}, {3'd1, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_four_hits();
    test_deep_buffer();
    test_overflow();
    test_backpressure();
    test_clear_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
